// File: rtl/timer_phase_controller_if.sv
// Bundles the control, configuration, timer and status signals of timer_phase_controller.
// The master side drives commands and the timer tick; the slave side is the sequencer.
interface timer_phase_controller_if #(
  parameter int NUM_PHASES = 4,
  parameter int DUR_W      = 8
);
  localparam int PH_W = $clog2(NUM_PHASES);

  logic                  start;
  logic                  stop;
  logic                  hold;
  logic                  cfg_we;
  logic [PH_W-1:0]       cfg_addr;
  logic [DUR_W-1:0]      cfg_dur;
  logic                  tick;
  logic                  timer_en;
  logic                  timer_clr;
  logic [PH_W-1:0]       phase;
  logic [NUM_PHASES-1:0] phase_onehot;
  logic [DUR_W-1:0]      remaining;
  logic                  busy;
  logic                  phase_done;
  logic                  cycle_done;

  modport master (
    output start, stop, hold, cfg_we, cfg_addr, cfg_dur, tick,
    input  timer_en, timer_clr, phase, phase_onehot, remaining, busy,
           phase_done, cycle_done
  );

  modport slave (
    input  start, stop, hold, cfg_we, cfg_addr, cfg_dur, tick,
    output timer_en, timer_clr, phase, phase_onehot, remaining, busy,
           phase_done, cycle_done
  );
endinterface

// File: rtl/timer_phase_controller.sv
// Steps a shared prescaler timer through NUM_PHASES programmable phases, counting
// DUR timer ticks per phase and pulsing phase_done / cycle_done at the boundaries.
module timer_phase_controller #(
  parameter int NUM_PHASES  = 4,
  parameter int DUR_W       = 8,
  parameter int DEFAULT_DUR = 5,
  parameter int LOOP        = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  timer_phase_controller_if.slave   bus
);
  localparam int PH_W = $clog2(NUM_PHASES);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
  localparam logic [DUR_W-1:0] DUR_RESET  = DUR_W'(DEFAULT_DUR);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t           state;
  logic [PH_W-1:0]  phase_q;
  logic [DUR_W-1:0] remaining_q;
  logic             phase_done_q;
  logic             cycle_done_q;
  logic [DUR_W-1:0] dur_table [NUM_PHASES];
  logic [DUR_W-1:0] table_dur;
  logic [DUR_W-1:0] load_dur;

  // Writes may land at any time; a running phase only sees them on its next LOAD.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        dur_table[i] <= DUR_RESET;
      end
    end else if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_PHASES)) begin
      dur_table[bus.cfg_addr] <= bus.cfg_dur;
    end
  end

  assign table_dur = dur_table[phase_q];
  assign load_dur  = (table_dur == '0) ? DUR_ONE : table_dur;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase_q      <= '0;
      remaining_q  <= '0;
      phase_done_q <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      phase_done_q <= 1'b0;
      cycle_done_q <= 1'b0;
      // stop overrides everything, including a tick that would finish the phase.
      if (bus.stop) begin
        state       <= IDLE;
        phase_q     <= '0;
        remaining_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state   <= LOAD;
              phase_q <= '0;
            end
          end
          LOAD: begin
            remaining_q <= load_dur;
            state       <= RUN;
          end
          RUN: begin
            if (bus.hold) begin
              state <= HOLD;
            end else if (bus.tick) begin
              if (remaining_q > DUR_ONE) begin
                remaining_q <= remaining_q - DUR_ONE;
              end else begin
                remaining_q  <= '0;
                phase_done_q <= 1'b1;
                if (phase_q != LAST_PHASE) begin
                  phase_q <= phase_q + PH_ONE;
                  state   <= LOAD;
                end else begin
                  cycle_done_q <= 1'b1;
                  if (LOOP != 0) begin
                    phase_q <= '0;
                    state   <= LOAD;
                  end else begin
                    state <= IDLE;
                  end
                end
              end
            end
          end
          HOLD: begin
            if (!bus.hold) begin
              state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // HOLD leaves timer_clr low so the timer keeps its partial prescale count.
  assign bus.timer_en     = (state == RUN);
  assign bus.timer_clr    = (state == IDLE) || (state == LOAD);
  assign bus.busy         = (state != IDLE);
  assign bus.phase        = phase_q;
  assign bus.remaining    = remaining_q;
  assign bus.phase_done   = phase_done_q;
  assign bus.cycle_done   = cycle_done_q;
  assign bus.phase_onehot = (state == IDLE) ? '0 : (NUM_PHASES'(1) << phase_q);
endmodule

// File: tb/tb_timer_phase_controller.sv
// Directed bench for timer_phase_controller: a looping instance checked through
// load/pulse scoreboards, plus a non-looping instance for the one-shot sequence.
module tb_timer_phase_controller;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   pd_count = 0;
  logic prev_load = 1'b0;

  typedef struct packed {
    logic [1:0] ph;
    logic       cd;
  } pulse_t;

  logic [7:0] load_q [$];
  pulse_t     pd_q [$];

  timer_phase_controller_if #(.NUM_PHASES(4), .DUR_W(8)) bus1 ();
  timer_phase_controller_if #(.NUM_PHASES(4), .DUR_W(8)) bus2 ();

  timer_phase_controller #(
    .NUM_PHASES(4), .DUR_W(8), .DEFAULT_DUR(5), .LOOP(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );

  timer_phase_controller #(
    .NUM_PHASES(4), .DUR_W(8), .DEFAULT_DUR(5), .LOOP(0)
  ) dut_once (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // One timer tick followed by two quiet cycles.
  task automatic applyStimulus();
    bus1.tick = 1'b1;
    stepClock();
    bus1.tick = 1'b0;
    stepClock();
    stepClock();
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [7:0] dur);
    bus1.cfg_we   = 1'b1;
    bus1.cfg_addr = addr;
    bus1.cfg_dur  = dur;
    stepClock();
    bus1.cfg_we   = 1'b0;
  endtask

  task automatic pushPulse(input logic [1:0] ph, input logic cd);
    pulse_t p;
    p.ph = ph;
    p.cd = cd;
    pd_q.push_back(p);
  endtask

  task automatic runTicked(input int target, input int budget);
    int cnt = 0;
    while (pd_count < target && cnt < budget) begin
      bus1.tick = (cnt % 3 == 2);
      stepClock();
      cnt++;
    end
    bus1.tick = 1'b0;
    checkOutput("tick_run_timeout", (pd_count >= target), 1);
  endtask

  task automatic stopAndCheck(input string tag);
    bus1.stop = 1'b1;
    stepClock();
    bus1.stop = 1'b0;
    checkOutput({tag, "_busy"}, bus1.busy, 0);
    checkOutput({tag, "_phase"}, bus1.phase, 0);
    checkOutput({tag, "_rem"}, bus1.remaining, 0);
    stepClock();
    checkOutput({tag, "_loadq_empty"}, load_q.size(), 0);
    checkOutput({tag, "_pdq_empty"}, pd_q.size(), 0);
  endtask

  // Scoreboard monitor: loaded durations and phase/cycle pulses of the looping instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_load && bus1.busy) begin
        if (load_q.size() == 0) checkOutput("load_unexpected", load_q.size(), 1);
        else checkOutput("load_remaining", bus1.remaining, load_q.pop_front());
      end
      if (bus1.phase_done || bus1.cycle_done) begin
        pd_count++;
        if (pd_q.size() == 0) begin
          checkOutput("pulse_unexpected", pd_q.size(), 1);
        end else begin
          pulse_t p;
          p = pd_q.pop_front();
          checkOutput("pulse_phase_done", bus1.phase_done, 1);
          checkOutput("pulse_next_phase", bus1.phase, p.ph);
          checkOutput("pulse_cycle_done", bus1.cycle_done, p.cd);
          if (bus1.busy) checkOutput("load_timer_clr", {bus1.timer_clr, bus1.timer_en}, 2'b10);
        end
      end
      prev_load = bus1.busy && bus1.timer_clr;
    end else begin
      prev_load = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  cnt;
    int  pd2;
    logic saw_cd;

    reset_n = 1'b0;
    bus1.start = 0; bus1.stop = 0; bus1.hold = 0; bus1.cfg_we = 0;
    bus1.cfg_addr = '0; bus1.cfg_dur = '0; bus1.tick = 0;
    bus2.start = 0; bus2.stop = 0; bus2.hold = 0; bus2.cfg_we = 0;
    bus2.cfg_addr = '0; bus2.cfg_dur = '0; bus2.tick = 0;
    stepClock();
    stepClock();
    checkOutput("rst_timer_clr", bus1.timer_clr, 1);
    checkOutput("rst_timer_en", bus1.timer_en, 0);
    checkOutput("rst_busy", bus1.busy, 0);
    checkOutput("rst_phase", bus1.phase, 0);
    checkOutput("rst_remaining", bus1.remaining, 0);
    checkOutput("rst_onehot", bus1.phase_onehot, 0);
    checkOutput("rst_pulses", {bus1.phase_done, bus1.cycle_done}, 0);
    reset_n = 1'b1;
    stepClock();

    // Default durations, looping sequence.
    for (int i = 0; i < 5; i++) load_q.push_back(8'd5);
    pushPulse(2'd1, 1'b0); pushPulse(2'd2, 1'b0);
    pushPulse(2'd3, 1'b0); pushPulse(2'd0, 1'b1);
    bus1.start = 1'b1;
    stepClock();
    bus1.start = 1'b0;
    checkOutput("t1_load_outputs", {bus1.busy, bus1.timer_clr, bus1.timer_en}, 3'b110);
    stepClock();
    checkOutput("t1_run_en", bus1.timer_en, 1);
    checkOutput("t1_run_rem", bus1.remaining, 5);
    checkOutput("t1_run_onehot", bus1.phase_onehot, 4'b0001);
    runTicked(pd_count + 4, 600);
    stepClock();
    checkOutput("t1_loop_phase", bus1.phase, 0);
    checkOutput("t1_loop_busy", bus1.busy, 1);
    stopAndCheck("t1_stop");

    // Programmed table including a zero entry.
    cfgWrite(2'd0, 8'd2); cfgWrite(2'd1, 8'd0);
    cfgWrite(2'd2, 8'd3); cfgWrite(2'd3, 8'd1);
    load_q.push_back(8'd2); load_q.push_back(8'd1); load_q.push_back(8'd3);
    load_q.push_back(8'd1); load_q.push_back(8'd2);
    pushPulse(2'd1, 1'b0); pushPulse(2'd2, 1'b0);
    pushPulse(2'd3, 1'b0); pushPulse(2'd0, 1'b1);
    bus1.start = 1'b1;
    stepClock();
    bus1.start = 1'b0;
    checkOutput("t2_load_clr", bus1.timer_clr, 1);
    stepClock();
    checkOutput("t2_run_rem", bus1.remaining, 2);
    runTicked(pd_count + 4, 300);
    stepClock();
    stopAndCheck("t2_stop");

    // Hold, live cfg write, and stop on the final tick.
    cfgWrite(2'd0, 8'd2); cfgWrite(2'd1, 8'd3);
    cfgWrite(2'd2, 8'd2); cfgWrite(2'd3, 8'd1);
    load_q.push_back(8'd2); load_q.push_back(8'd3); load_q.push_back(8'd2);
    pushPulse(2'd1, 1'b0); pushPulse(2'd2, 1'b0);
    bus1.start = 1'b1;
    stepClock();
    bus1.start = 1'b0;
    stepClock();
    applyStimulus();
    applyStimulus();
    checkOutput("t3_phase", bus1.phase, 1);
    checkOutput("t3_rem", bus1.remaining, 3);
    checkOutput("t3_onehot", bus1.phase_onehot, 4'b0010);
    cfgWrite(2'd1, 8'd6);
    checkOutput("t6_live_rem", bus1.remaining, 3);
    bus1.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus1.tick = (i % 3 == 0);
      stepClock();
    end
    bus1.tick = 1'b0;
    checkOutput("t3_hold_rem", bus1.remaining, 3);
    checkOutput("t3_hold_ctrl", {bus1.busy, bus1.timer_en, bus1.timer_clr}, 3'b100);
    bus1.hold = 1'b0;
    stepClock();
    checkOutput("t3_release_en", bus1.timer_en, 1);
    checkOutput("t3_release_rem", bus1.remaining, 3);
    applyStimulus();
    checkOutput("t3_resume_rem", bus1.remaining, 2);
    applyStimulus();
    applyStimulus();
    checkOutput("t4_phase2", bus1.phase, 2);
    applyStimulus();
    checkOutput("t4_rem1", bus1.remaining, 1);
    bus1.stop = 1'b1;
    bus1.tick = 1'b1;
    stepClock();
    bus1.stop = 1'b0;
    bus1.tick = 1'b0;
    checkOutput("t4_busy", bus1.busy, 0);
    checkOutput("t4_phase", bus1.phase, 0);
    checkOutput("t4_rem", bus1.remaining, 0);
    checkOutput("t4_no_pulse", {bus1.phase_done, bus1.cycle_done}, 0);
    checkOutput("t4_onehot", bus1.phase_onehot, 0);
    stepClock();
    checkOutput("t4_pdq_empty", pd_q.size(), 0);

    // Next pass picks up the duration written while phase 1 was live.
    load_q.push_back(8'd2); load_q.push_back(8'd6);
    pushPulse(2'd1, 1'b0);
    bus1.start = 1'b1;
    stepClock();
    bus1.start = 1'b0;
    stepClock();
    applyStimulus();
    applyStimulus();
    checkOutput("t6_next_rem", bus1.remaining, 6);
    stopAndCheck("t6_stop");

    // One-shot instance: mid-run start ignored, ends in IDLE after phase 3.
    bus2.start = 1'b1;
    stepClock();
    bus2.start = 1'b0;
    cnt = 0;
    pd2 = 0;
    saw_cd = 1'b0;
    while (!saw_cd && cnt < 400) begin
      bus2.tick  = (cnt % 3 == 2);
      bus2.start = (cnt == 22);
      stepClock();
      if (cnt == 22) begin
        checkOutput("t5_midstart_phase", bus2.phase, 1);
        checkOutput("t5_midstart_en", bus2.timer_en, 1);
      end
      if (bus2.phase_done) pd2++;
      if (bus2.cycle_done) begin
        saw_cd = 1'b1;
        checkOutput("t5_end_busy", bus2.busy, 0);
        checkOutput("t5_end_phase", bus2.phase, 3);
        checkOutput("t5_end_pd_count", pd2, 4);
        checkOutput("t5_end_onehot", bus2.phase_onehot, 0);
      end
      cnt++;
    end
    bus2.tick  = 1'b0;
    bus2.start = 1'b0;
    checkOutput("t5_timeout", saw_cd, 1);
    stepClock();
    checkOutput("t5_idle_after", {bus2.busy, bus2.cycle_done, bus2.timer_clr}, 3'b001);
    checkOutput("t5_phase_held", bus2.phase, 3);

    stepClock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
